// File: rtl/puf_crp_controller.sv
// Arbiter-PUF challenge driver and response packer; optional 3-pass majority vote under PUF_MAJORITY_VOTE_EN.
// Latency: M*(RST_CYCLES+SETTLE_CYCLES+1) clocks per word (x3 with voting) from the edge that samples start.
// Backpressure: the finished word is held in DONE until resp_valid&&resp_ready; start is ignored until then.
module puf_crp_controller #(
    parameter int             N             = 128,
    parameter int             M             = 32,
    parameter logic [N-1:0]   TAPS          = N'((128'd1 << 127) | (128'd1 << 125) | (128'd1 << 100) | (128'd1 << 98)),
    parameter int             RST_CYCLES    = 2,
    parameter int             SETTLE_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         seed_load,
    input  logic [N-1:0] seed,
    output logic [N-1:0] challenge,
    output logic         puf_in,
    output logic         puf_reset,
    input  logic         puf_out,
    output logic [M-1:0] resp_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         busy
);

    localparam int CW       = (M > 1) ? $clog2(M) : 1;
    localparam int HOLD_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, SAMPLE, DONE} state_t;

    state_t        state, state_next;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] bit_cnt;
    logic          sync_q1, sync_q2;
    logic          hold_done;
    logic          launch_next;
    logic          last_pass;
    logic          sample_bit;

    assign hold_done = ((state == ARM)    && (hold_cnt == HW'(RST_CYCLES - 1))) ||
                       ((state == LAUNCH) && (hold_cnt == HW'(SETTLE_CYCLES - 1)));
    assign launch_next = (state_next == LAUNCH) || (state_next == SAMPLE);
    assign busy        = (state != IDLE);
    assign resp_valid  = (state == DONE);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] pass_cnt;
    logic [1:0] votes;

    // votes holds the first two samples of the current challenge; the third comes straight from the synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt <= 2'd0;
            votes    <= 2'd0;
        end else if (state == SAMPLE) begin
            if (pass_cnt == 2'd2) begin
                pass_cnt <= 2'd0;
                votes    <= 2'd0;
            end else begin
                pass_cnt <= pass_cnt + 2'd1;
                votes    <= {votes[0], sync_q2};
            end
        end
    end

    assign last_pass  = (pass_cnt == 2'd2);
    assign sample_bit = (votes[1] & votes[0]) | (votes[1] & sync_q2) | (votes[0] & sync_q2);
`else
    assign last_pass  = 1'b1;
    assign sample_bit = sync_q2;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = ARM;
            ARM:     if (hold_done) state_next = LAUNCH;
            LAUNCH:  if (hold_done) state_next = SAMPLE;
            SAMPLE: begin
                if (last_pass && (bit_cnt == CW'(M - 1))) state_next = DONE;
                else                                      state_next = ARM;
            end
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            challenge <= '1;
            puf_in    <= 1'b0;
            puf_reset <= 1'b1;
            resp_data <= '0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
        end else begin
            state     <= state_next;
            sync_q1   <= puf_out;
            sync_q2   <= sync_q1;
            // launch/clear are registered from the next state so they line up with the state register
            puf_in    <= launch_next;
            puf_reset <= !launch_next;

            if ((state_next != state) || !((state == ARM) || (state == LAUNCH)))
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + HW'(1);

            case (state)
                IDLE: begin
                    if (seed_load)
                        challenge <= (seed == '0) ? N'(1) : seed;
                    if (start) begin
                        bit_cnt   <= '0;
                        resp_data <= '0;
                    end
                end
                SAMPLE: begin
                    if (last_pass) begin
                        resp_data[bit_cnt] <= sample_bit;
                        challenge          <= {challenge[N-2:0], ^(challenge & TAPS)};
                        bit_cnt            <= bit_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
